// File: rtl/pulse_merger_pkg.sv
// Shared types and helpers for the pulse merger: FSM state encoding and counter capacity.
package pulse_merger_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGather = 2'd1,
        StEmit   = 2'd2
    } state_e;

    // Largest value a pending-pulse counter of the given width can hold.
    function automatic int unsigned max_count(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pulse_merger.sv
// Accumulates single-cycle input pulses and replays them as one contiguous output pulse
// whose length equals the number of accepted input units.
module pulse_merger
    import pulse_merger_pkg::*;
#(
    parameter int unsigned PULSE_COUNTER_WIDTH = 3,
    parameter int unsigned GAP_CYCLES          = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic pulse_in,
    output logic pulse_out,
    output logic busy
);

    localparam int unsigned CW = PULSE_COUNTER_WIDTH;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] MaxCount = CW'(max_count(CW));
    localparam logic [GW-1:0] GapLast  = GW'(GAP_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          pulse_out_q, pulse_out_d;

    logic          accepted;
    logic [CW-1:0] count_inc;
    logic [CW-1:0] emit_next;

    assign accepted  = pulse_in & ~busy;
    assign count_inc = count_q + CW'(1);
    // count is at least 1 while emitting, so this cannot underflow.
    assign emit_next = count_q - CW'(1) + CW'(accepted);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= StIdle;
            count_q     <= '0;
            gap_q       <= '0;
            pulse_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            gap_q       <= gap_d;
            pulse_out_q <= pulse_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        gap_d       = gap_q;
        pulse_out_d = pulse_out_q;
        unique case (state_q)
            StIdle: begin
                if (accepted) begin
                    count_d = CW'(1);
                    gap_d   = '0;
                    state_d = StGather;
                end
            end
            StGather: begin
                if (accepted) begin
                    count_d = count_inc;
                    gap_d   = '0;
                    // Saturation flush: emit immediately rather than waiting for the gap.
                    if (count_inc == MaxCount) begin
                        state_d     = StEmit;
                        pulse_out_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                    if (gap_q == GapLast) begin
                        state_d     = StEmit;
                        pulse_out_d = 1'b1;
                    end
                end
            end
            StEmit: begin
                count_d = emit_next;
                if (emit_next == '0) begin
                    state_d     = StIdle;
                    pulse_out_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                count_d     = '0;
                gap_d       = '0;
                pulse_out_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy      = (count_q == MaxCount);
        pulse_out = pulse_out_q;
    end

endmodule

// File: tb/tb_pulse_merger.sv
// Directed bench for pulse_merger (W=3, GAP=2): per-cycle vector table plus corner sequences.
module tb_pulse_merger;

    logic clock;
    logic resetn;
    logic pulse_in;
    logic pulse_out;
    logic busy;

    int checks = 0;
    int errors = 0;
    int high_cnt = 0;
    int rises = 0;
    logic prev_out = 1'b0;

    pulse_merger #(
        .PULSE_COUNTER_WIDTH(3),
        .GAP_CYCLES         (2)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .pulse_in (pulse_in),
        .pulse_out(pulse_out),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic rst_n;
        logic pin;
        logic exp_out;
        logic exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic p, input logic eo, input logic eb);
        vec_t v;
        v.rst_n    = r;
        v.pin      = p;
        v.exp_out  = eo;
        v.exp_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic r, input logic p);
        resetn   = r;
        pulse_in = p;
        @(posedge clock);
        #1;
        if (pulse_out) high_cnt++;
        if (pulse_out && !prev_out) rises++;
        prev_out = pulse_out;
    endtask

    initial begin
        int acc;
        logic pin;
        resetn   = 1'b0;
        pulse_in = 1'b0;
        #2;

        // Reset
        add(0, 0, 0, 0);
        // Single one-cycle pulse: output rises on 2nd low edge, lasts 1 cycle
        add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 0, 1, 0); add(1, 0, 0, 0); add(1, 0, 0, 0);
        // Four pulses separated by single lows -> one 4-cycle output
        add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 0);
        add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 0);
        add(1, 0, 1, 0); add(1, 0, 1, 0); add(1, 0, 1, 0); add(1, 0, 1, 0);
        add(1, 0, 0, 0); add(1, 0, 0, 0);
        // Burst of 3, 5 lows, burst of 2 -> pulses of 3 and 2
        add(1, 1, 0, 0); add(1, 1, 0, 0); add(1, 1, 0, 0);
        add(1, 0, 0, 0); add(1, 0, 1, 0); add(1, 0, 1, 0); add(1, 0, 1, 0); add(1, 0, 0, 0);
        add(1, 1, 0, 0); add(1, 1, 0, 0); add(1, 0, 0, 0); add(1, 0, 1, 0); add(1, 0, 1, 0);
        add(1, 0, 0, 0);
        // Held high to saturation, one extra unit dropped while busy -> 7-cycle output
        add(1, 1, 0, 0); add(1, 1, 0, 0); add(1, 1, 0, 0); add(1, 1, 0, 0);
        add(1, 1, 0, 0); add(1, 1, 0, 0); add(1, 1, 1, 1); add(1, 1, 1, 0);
        add(1, 0, 1, 0); add(1, 0, 1, 0); add(1, 0, 1, 0); add(1, 0, 1, 0); add(1, 0, 1, 0);
        add(1, 0, 0, 0); add(1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].pin);
            check($sformatf("vec[%0d] pulse_out", i), int'(pulse_out), int'(vecs[i].exp_out));
            check($sformatf("vec[%0d] busy", i), int'(busy), int'(vecs[i].exp_busy));
        end

        // Two pulses, then two more injected during emission -> one 4-cycle pulse
        high_cnt = 0;
        rises    = 0;
        step(1, 1); step(1, 1); step(1, 0); step(1, 0);
        check("inject first emit cycle", int'(pulse_out), 1);
        step(1, 1); step(1, 1);
        for (int i = 0; i < 6; i++) step(1, 0);
        check("inject high cycles", high_cnt, 4);
        check("inject single pulse", rises, 1);

        // Reset during gather discards pending units
        high_cnt = 0;
        step(1, 1); step(1, 1); step(1, 1);
        step(0, 0);
        check("reset gather busy", int'(busy), 0);
        for (int i = 0; i < 8; i++) step(1, 0);
        check("reset gather no output", high_cnt, 0);

        // Reset during emission drops pulse_out on that edge
        step(1, 1); step(1, 1); step(1, 0); step(1, 0);
        check("reset emit pre", int'(pulse_out), 1);
        step(0, 0);
        check("reset emit out", int'(pulse_out), 0);

        // Random stream: output high cycles must equal accepted units
        high_cnt = 0;
        acc      = 0;
        for (int i = 0; i < 200; i++) begin
            pin = logic'($urandom_range(0, 1)) & ~busy;
            if (pin) acc++;
            step(1, pin);
        end
        for (int i = 0; i < 30; i++) step(1, 0);
        check("random total high", high_cnt, acc);
        check("random end out", int'(pulse_out), 0);
        check("random end busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_merger.md
Name: pulse_merger

Overview:
- Inverse of the pulse separator in the pulse library: accumulates single-cycle input pulses and replays them as one contiguous high pulse.
- The output pulse is as long, in cycles, as the number of accepted input high cycles.
- Used where a burst of event strobes must become a level-style "active for N cycles" window, for example to re-merge separated pulses after a clock-domain or rate crossing.
- A saturating counter with a busy flag gives back-pressure, exactly like the separator's interface.

Parameters:
- PULSE_COUNTER_WIDTH, 3, width of the pending-pulse counter. Capacity MAX = 2**PULSE_COUNTER_WIDTH - 1.
- GAP_CYCLES, 2, number of consecutive low input cycles that closes a burst and starts emission. Must be at least 1. Gap counter width is $clog2(GAP_CYCLES+1).

Ports:
- clock  input  1  single clock; all logic on its rising edge.
- resetn  input  1  reset, synchronous and active-low.
- pulse_in  input  1  each sampled high cycle is one pulse unit.
- pulse_out  output  1  registered; contiguous high for the merged count.
- busy  output  1  counter at MAX; pulse_in is ignored while high.

Behaviour:
- State register takes one of IDLE, GATHER, EMIT.
- Registers are state, count[PULSE_COUNTER_WIDTH], gap and pulse_out.
- busy = (count == MAX). It is decoded combinationally from the register, so there is no extra latency.
- accepted = pulse_in & ~busy. Dropped input units are lost silently.
- Reset (resetn low at an edge) drives state to IDLE and count, gap and pulse_out to 0; busy reads 0.
- Reset mid-operation discards all pending units, and pulse_out falls on that edge.
- IDLE:
  - accepted: count <= 1, gap <= 0, go to GATHER.
  - otherwise: stay in IDLE.
- GATHER:
  - accepted: count <= count+1, gap <= 0.
  - not accepted: gap <= gap+1.
  - Transition to EMIT with pulse_out <= 1 when gap+1 == GAP_CYCLES, or when count+1 == MAX (saturation flush, no gap wait).
  - An input high on the cycle that would have completed the gap resets gap and keeps the state in GATHER.
- EMIT:
  - pulse_out stays high.
  - next = count - 1 + accepted, so input units arriving during emission extend the same pulse.
  - If next == 0: go to IDLE and set pulse_out <= 0 on that edge. Otherwise count <= next.
- Invariant: total pulse_out high cycles equals the total number of accepted units.
- Output latency: pulse_out rises on the GAP_CYCLES-th consecutive edge that samples pulse_in low after the last accepted unit. On saturation it rises on the edge where count reaches MAX.
- Back-to-back bursts: an accepted unit on the edge that leaves EMIT for IDLE cannot occur, because next would be non-zero and emission would continue. A unit arriving in IDLE therefore always starts a fresh GATHER, giving a low output gap of at least GAP_CYCLES+1 cycles between merged pulses.
- Counter arithmetic is unsigned. In EMIT, count never underflows, since count ≥ 1 there. Increments never exceed MAX, because accepted is gated by busy.

Decomposition:
- Shared package pulse_merger_pkg holds:
  - the state enum typedef (IDLE, GATHER, EMIT), 2 bits;
  - a function returning MAX for a given width.
- No sub-module is needed. The counter and FSM stay in one module of about 150 lines.

Test Plan:
- Single one-cycle pulse (W=3, GAP=2) -> pulse_out high exactly 1 cycle, rising on the 2nd edge sampling pulse_in low; busy stays 0.
- Four one-cycle pulses separated by single low cycles -> one contiguous 4-cycle output; no output during the train.
- Burst of 3 pulses, 5 low cycles, then burst of 2 -> two separate output pulses of 3 and 2 cycles.
- pulse_in held high until busy (7 units), then low -> busy high for 1 cycle, output starts on the saturating edge, one contiguous 7-cycle pulse; extra input while busy produces no extra cycles.
- 2 pulses, then 2 more pulses injected during EMIT -> a single contiguous 4-cycle output.
- resetn low for 1 cycle during GATHER with 3 pending units -> no output pulse, busy 0.
- 200 random cycles, pulse_in = random & ~busy -> total pulse_out high cycles == count of accepted units; pulse_out low at the end.
